// File: rtl/channel_flow_arbiter_if.sv
// Handshake and valve-drive bundle between the inlet requesters and the channel arbiter.
interface channel_flow_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DOSE_W = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DOSE_W-1:0] dose_len;
  logic                    abort;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        valve_open;
  logic                    flush_valve;
  logic                    busy;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic                    aborted;
  logic                    err;

  // Requester side: drives requests and dose lengths, observes grants and completion.
  modport master (
    output req, dose_len, abort,
    input  gnt, valve_open, flush_valve, busy, done, done_id, aborted, err
  );

  // Arbiter side.
  modport slave (
    input  req, dose_len, abort,
    output gnt, valve_open, flush_valve, busy, done, done_id, aborted, err
  );
endinterface

// File: rtl/channel_flow_arbiter.sv
// Round-robin sequencer sharing one microfluidic channel among N_REQ inlets.
// Each dose runs: settle (all valves closed) -> inlet valve open -> flush.
module channel_flow_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DOSE_W        = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int FLUSH_CYCLES  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  channel_flow_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int S_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int F_W   = $clog2(FLUSH_CYCLES + 1);
  localparam int SF_W  = (S_W > F_W) ? S_W : F_W;
  localparam int CNT_W = (DOSE_W > SF_W) ? DOSE_W : SF_W;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DOSE, ST_FLUSH} state_t;

  state_t             r_state, w_state_next;
  logic [ID_W-1:0]    r_ptr, w_ptr_next;
  logic [ID_W-1:0]    r_id, w_id_next;
  logic [DOSE_W-1:0]  r_dose, w_dose_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_cut, w_cut_next;
  logic               w_done_next, w_aborted_next, w_err_next;
  logic [ID_W-1:0]    w_done_id_next;

  logic [N_REQ-1:0]   r_gnt, r_valve;
  logic               r_flush, r_busy, r_done, r_aborted, r_err;
  logic [ID_W-1:0]    r_done_id;

  logic [DOSE_W-1:0]  w_dose_arr [N_REQ];
  logic               w_win_found;
  logic [ID_W-1:0]    w_win_id;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_win_inc, w_id_inc;
  logic               w_stop;
  logic [CNT_W-1:0]   w_dose_last;

  // Unpack the flat dose bus into one slice per inlet.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dose
    assign w_dose_arr[gi] = bus.dose_len[gi*DOSE_W +: DOSE_W];
  end

  // Round-robin pick: first request at or above the pointer, wrapping.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_sum       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
      if (!w_win_found && bus.req[w_sum[ID_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_id    = w_sum[ID_W-1:0];
      end
    end
  end

  assign w_win_inc   = (w_win_id == ID_W'(N_REQ-1)) ? '0 : w_win_id + 1'b1;
  assign w_id_inc    = (r_id == ID_W'(N_REQ-1)) ? '0 : r_id + 1'b1;
  assign w_stop      = bus.abort | ~bus.req[r_id];
  assign w_dose_last = CNT_W'(r_dose) - CNT_W'(1);

  // Next-state, counter and completion-report logic.
  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_id_next      = r_id;
    w_dose_next    = r_dose;
    w_cnt_next     = r_cnt + 1'b1;
    w_cut_next     = r_cut;
    w_done_next    = 1'b0;
    w_done_id_next = r_done_id;
    w_aborted_next = 1'b0;
    w_err_next     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        w_cut_next = 1'b0;
        if (w_win_found) begin
          w_id_next   = w_win_id;
          w_dose_next = w_dose_arr[w_win_id];
          if (w_dose_arr[w_win_id] == '0) begin
            // Nothing to move: report an error and let the next inlet in.
            w_done_next    = 1'b1;
            w_err_next     = 1'b1;
            w_done_id_next = w_win_id;
            w_ptr_next     = w_win_inc;
          end else begin
            w_state_next = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (w_stop) begin
          // No fluid admitted yet, so no flush is needed.
          w_state_next   = ST_IDLE;
          w_cnt_next     = '0;
          w_done_next    = 1'b1;
          w_aborted_next = 1'b1;
          w_done_id_next = r_id;
          w_ptr_next     = w_id_inc;
        end else if (r_cnt == CNT_W'(SETTLE_CYCLES-1)) begin
          w_state_next = ST_DOSE;
          w_cnt_next   = '0;
        end
      end
      ST_DOSE: begin
        if (w_stop) begin
          w_state_next = ST_FLUSH;
          w_cnt_next   = '0;
          w_cut_next   = 1'b1;
        end else if (r_cnt == w_dose_last) begin
          w_state_next = ST_FLUSH;
          w_cnt_next   = '0;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == CNT_W'(FLUSH_CYCLES-1)) begin
          w_state_next   = ST_IDLE;
          w_cnt_next     = '0;
          w_done_next    = 1'b1;
          w_aborted_next = r_cut;
          w_done_id_next = r_id;
          w_ptr_next     = w_id_inc;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_dose    <= '0;
      r_cnt     <= '0;
      r_cut     <= 1'b0;
      r_gnt     <= '0;
      r_valve   <= '0;
      r_flush   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_id      <= w_id_next;
      r_dose    <= w_dose_next;
      r_cnt     <= w_cnt_next;
      r_cut     <= w_cut_next;
      r_gnt     <= (w_state_next != ST_IDLE) ? (N_REQ'(1) << w_id_next) : '0;
      r_valve   <= (w_state_next == ST_DOSE) ? (N_REQ'(1) << w_id_next) : '0;
      r_flush   <= (w_state_next == ST_FLUSH);
      r_busy    <= (w_state_next != ST_IDLE);
      r_done    <= w_done_next;
      r_done_id <= w_done_id_next;
      r_aborted <= w_aborted_next;
      r_err     <= w_err_next;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.valve_open  = r_valve;
  assign bus.flush_valve = r_flush;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.done_id     = r_done_id;
  assign bus.aborted     = r_aborted;
  assign bus.err         = r_err;
endmodule
